// File: rtl/csc_former_encoder.sv
// Streams a column-major dense INT8 matrix into compressed-sparse-column words
// of {data, zero-run} and emits per-column cumulative entry counts and a zero terminator.
module csc_former_encoder #(
    parameter int MAX_ENTRIES = 200
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [5:0]  i_cfg_rows,
    input  logic [7:0]  i_cfg_cols,
    input  logic        i_din_valid,
    output logic        o_din_ready,
    input  logic [7:0]  i_din,
    output logic        o_dout_valid,
    input  logic        i_dout_ready,
    output logic [12:0] o_dout,
    output logic        o_addr_valid,
    output logic [7:0]  o_addr_out,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_overflow
);

    // One spad slot is reserved for the terminator word.
    localparam logic [7:0] LP_ENTRY_LIMIT = 8'(MAX_ENTRIES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ENC,
        S_TERM,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [5:0]  r_rows;
    logic [7:0]  r_cols;
    logic [4:0]  r_row;
    logic [7:0]  r_col;
    logic [4:0]  r_run;
    logic [7:0]  r_entries;
    logic [12:0] r_dout;
    logic        r_dout_vld;
    logic        r_term_sent;
    logic        r_addr_vld;
    logic [7:0]  r_addr;
    logic        r_ovf;

    logic        w_out_free;
    logic        w_din_ready;
    logic        w_hs;
    logic        w_last_row;
    logic        w_last_col;
    logic        w_nonzero;
    logic        w_room;
    logic        w_load;
    logic        w_term_load;
    logic        w_term_hs;
    logic        w_start_ok;
    logic        w_cfg_zero;
    logic [7:0]  w_entries_nxt;

    assign w_out_free    = !r_dout_vld || i_dout_ready;
    assign w_din_ready   = (r_state == S_ENC) && w_out_free;
    assign w_hs          = i_din_valid && w_din_ready;
    assign w_last_row    = ({1'b0, r_row} == (r_rows - 6'd1));
    assign w_last_col    = (r_col == (r_cols - 8'd1));
    assign w_nonzero     = (i_din != 8'd0);
    assign w_room        = (r_entries < LP_ENTRY_LIMIT);
    assign w_load        = w_hs && w_nonzero && w_room;
    assign w_term_load   = (r_state == S_TERM) && !r_term_sent && w_out_free;
    assign w_term_hs     = (r_state == S_TERM) && r_term_sent && r_dout_vld && i_dout_ready;
    assign w_start_ok    = (r_state == S_IDLE) && i_start;
    assign w_cfg_zero    = (i_cfg_rows == 6'd0) || (i_cfg_cols == 8'd0);
    assign w_entries_nxt = r_entries + {7'd0, w_load};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_nxt = w_cfg_zero ? S_TERM : S_ENC;
                end
            end
            S_ENC: begin
                if (w_hs && w_last_row && w_last_col) begin
                    w_state_nxt = S_TERM;
                end
            end
            S_TERM: begin
                if (w_term_hs) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rows      <= 6'd0;
            r_cols      <= 8'd0;
            r_row       <= 5'd0;
            r_col       <= 8'd0;
            r_run       <= 5'd0;
            r_entries   <= 8'd0;
            r_dout      <= 13'd0;
            r_dout_vld  <= 1'b0;
            r_term_sent <= 1'b0;
            r_addr_vld  <= 1'b0;
            r_addr      <= 8'd0;
            r_ovf       <= 1'b0;
        end else begin
            r_addr_vld <= 1'b0;

            // Configuration is captured once; later changes on the cfg inputs are ignored.
            if (w_start_ok) begin
                r_rows      <= i_cfg_rows;
                r_cols      <= i_cfg_cols;
                r_row       <= 5'd0;
                r_col       <= 8'd0;
                r_run       <= 5'd0;
                r_entries   <= 8'd0;
                r_ovf       <= 1'b0;
                r_term_sent <= 1'b0;
            end

            if (w_hs) begin
                if (w_nonzero) begin
                    r_run <= 5'd0;
                    if (!w_room) begin
                        r_ovf <= 1'b1;
                    end
                end else begin
                    r_run <= r_run + 5'd1;
                end
                r_entries <= w_entries_nxt;
                // Column end: publish the running entry count, including this element's word.
                if (w_last_row) begin
                    r_row      <= 5'd0;
                    r_run      <= 5'd0;
                    r_addr_vld <= 1'b1;
                    r_addr     <= w_entries_nxt;
                    r_col      <= w_last_col ? 8'd0 : r_col + 8'd1;
                end else begin
                    r_row <= r_row + 5'd1;
                end
            end

            // Output register: refill may coincide with a drain for full throughput.
            if (w_load) begin
                r_dout     <= {i_din, r_run};
                r_dout_vld <= 1'b1;
            end else if (w_term_load) begin
                r_dout      <= 13'd0;
                r_dout_vld  <= 1'b1;
                r_term_sent <= 1'b1;
            end else if (r_dout_vld && i_dout_ready) begin
                r_dout_vld <= 1'b0;
            end
        end
    end

    assign o_din_ready  = w_din_ready;
    assign o_dout_valid = r_dout_vld;
    assign o_dout       = r_dout;
    assign o_addr_valid = r_addr_vld;
    assign o_addr_out   = r_addr;
    assign o_busy       = (r_state == S_ENC) || (r_state == S_TERM);
    assign o_done       = (r_state == S_DONE);
    assign o_overflow   = r_ovf;

endmodule
